button_conditioner: RTL

- Upstream conditioning stage for the push-buttons feeding the Nios button PIO (4-bit button export).
- Synchronises raw KEY inputs and debounces them per channel.
- Presents a clean active-low level to the PIO, plus single-cycle press, release and auto-repeat strobes that the FPGA-side game logic (plane pitch/fire controls) consumes directly.

---
 rtl/button_pkg.sv | 20 ++
 rtl/button_channel.sv | 137 +++++++++++++
 rtl/button_conditioner.sv | 38 +++
 3 files changed

// File: rtl/button_pkg.sv
// Shared constants, timing helper and repeat-state encoding for the push-button
// conditioning path.
package button_pkg;

    localparam int CLK_HZ           = 50_000_000;
    localparam int DEBOUNCE_MS      = 10;
    localparam int REPEAT_DELAY_MS  = 500;
    localparam int REPEAT_PERIOD_MS = 100;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

    function automatic int cycles_from_ms(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, counting debouncer with press/release strobes,
// and an auto-repeat FSM driven by accepted press/release events.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 500_000,
    parameter int REPEAT_DELAY_CYCLES  = 25_000_000,
    parameter int REPEAT_PERIOD_CYCLES = 5_000_000
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic key_n,
    output logic btn_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic long_held
);

    localparam int DCNT_W  = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                             REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int RCNT_W  = ($clog2(RPT_MAX) < 1) ? 1 : $clog2(RPT_MAX);

    localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD_CYCLES - 1);

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              stable_q, stable_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    rpt_state_t        state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              repeat_q, repeat_d;
    logic              long_q, long_d;

    always_comb begin
        s1_d      = key_n;
        s2_d      = s1_q;
        stable_d  = stable_q;
        dcnt_d    = dcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        // Any bounce back to the accepted level restarts the stability count.
        if (s2_q == stable_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
            stable_d  = s2_q;
            dcnt_d    = '0;
            press_d   = stable_q;
            release_d = ~stable_q;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end

        state_d  = state_q;
        rcnt_d   = rcnt_q;
        repeat_d = 1'b0;
        long_d   = long_q;

        // Release wins over a repeat that would land in the same cycle.
        if (release_d) begin
            state_d = IDLE;
            rcnt_d  = '0;
            long_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_d) begin
                        state_d = DELAY;
                        rcnt_d  = DELAY_LAST;
                    end
                end
                DELAY: begin
                    if (rcnt_q == '0) begin
                        repeat_d = 1'b1;
                        long_d   = 1'b1;
                        rcnt_d   = PERIOD_LAST;
                        state_d  = REPEAT;
                    end else begin
                        rcnt_d = rcnt_q - 1'b1;
                    end
                end
                REPEAT: begin
                    if (rcnt_q == '0) begin
                        repeat_d = 1'b1;
                        rcnt_d   = PERIOD_LAST;
                    end else begin
                        rcnt_d = rcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                    long_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            stable_q  <= 1'b1;
            dcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            state_q   <= IDLE;
            rcnt_q    <= '0;
            repeat_q  <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            dcnt_q    <= dcnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            repeat_q  <= repeat_d;
            long_q    <= long_d;
        end
    end

    assign btn_n         = stable_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign long_held     = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw KEY inputs for the button PIO and emits per-button
// press/release/auto-repeat strobes for the game logic.
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN              = 4,
    parameter int DEBOUNCE_CYCLES      = cycles_from_ms(DEBOUNCE_MS),
    parameter int REPEAT_DELAY_CYCLES  = cycles_from_ms(REPEAT_DELAY_MS),
    parameter int REPEAT_PERIOD_CYCLES = cycles_from_ms(REPEAT_PERIOD_MS)
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [NUM_BTN-1:0] key_n_in,
    output logic [NUM_BTN-1:0] btn_export_n,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse,
    output logic [NUM_BTN-1:0] long_held
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
        ) u_chan (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .key_n         (key_n_in[i]),
            .btn_n         (btn_export_n[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i]),
            .long_held     (long_held[i])
        );
    end

endmodule
